// File: rtl/fpu_ext_to_int64.sv
// rtl/fpu_ext_to_int64.sv - 80-bit extended real to rounded 64-bit magnitude + sign, BCD range checked
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   enable     level request, held high until done
//   real_in    [79] sign, [78:64] biased exponent, [63:0] mantissa with explicit integer bit
//   round_mode 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 chop
//   int_out    rounded magnitude (0 on error)
//   sign_out   sign of the captured operand
//   done       result valid; held while enable stays high
//   error      inf/NaN, too large, or rounded magnitude above 10^18-1
//   inexact    guard|sticky nonzero after alignment
module fpu_ext_to_int64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [79:0] real_in,
  input  logic [1:0]  round_mode,
  output logic [63:0] int_out,
  output logic        sign_out,
  output logic        done,
  output logic        error,
  output logic        inexact
);

  localparam logic [15:0] BIAS_SHIFT = 16'd16446;
  localparam logic [63:0] BCD_MAX    = 64'h0DE0_B6B3_A763_FFFF;
  localparam logic [6:0]  MAX_SHIFT  = 7'd66;

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t      state;
  logic        sign_r;
  logic [63:0] mant;
  logic        guard;
  logic        sticky;
  logic [1:0]  rmode;
  logic [6:0]  cnt;

  // Capture-side decode of the incoming operand.
  logic [14:0] exp_field;
  logic [15:0] eff_exp;
  logic [15:0] shift_dist;
  logic        range_bad;
  logic [6:0]  cnt_init;

  always_comb begin
    exp_field  = real_in[78:64];
    // Denormals share the scale of exponent 1.
    eff_exp    = {1'b0, (exp_field == 15'd0) ? 15'd1 : exp_field};
    range_bad  = (exp_field == 15'h7FFF) || (eff_exp > BIAS_SHIFT);
    shift_dist = BIAS_SHIFT - eff_exp;
    // Beyond 66 shifts everything is already in sticky; clamp the count.
    cnt_init   = (shift_dist > {9'd0, MAX_SHIFT}) ? MAX_SHIFT : shift_dist[6:0];
  end

  // Rounding increment and range check on the aligned mantissa.
  logic        inc;
  logic [64:0] sum;
  logic        too_big;

  always_comb begin
    inc = 1'b0;
    case (rmode)
      2'b00:   inc = guard & (mant[0] | sticky);
      2'b01:   inc = sign_r & (guard | sticky);
      2'b10:   inc = ~sign_r & (guard | sticky);
      default: inc = 1'b0;
    endcase
    // 65-bit sum so an all-ones mantissa plus increment cannot wrap into range.
    sum     = {1'b0, mant} + {64'd0, inc};
    too_big = sum > {1'b0, BCD_MAX};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sign_r   <= 1'b0;
      mant     <= 64'd0;
      guard    <= 1'b0;
      sticky   <= 1'b0;
      rmode    <= 2'b00;
      cnt      <= 7'd0;
      int_out  <= 64'd0;
      sign_out <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            sign_r <= real_in[79];
            mant   <= real_in[63:0];
            rmode  <= round_mode;
            guard  <= 1'b0;
            sticky <= 1'b0;
            cnt    <= cnt_init;
            if (range_bad) begin
              int_out  <= 64'd0;
              sign_out <= real_in[79];
              error    <= 1'b1;
              inexact  <= 1'b0;
              state    <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (cnt == 7'd0) begin
            state <= ROUND;
          end else begin
            sticky <= sticky | guard;
            guard  <= mant[0];
            mant   <= mant >> 1;
            cnt    <= cnt - 7'd1;
          end
        end
        ROUND: begin
          int_out  <= too_big ? 64'd0 : sum[63:0];
          error    <= too_big;
          inexact  <= guard | sticky;
          sign_out <= sign_r;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          // The error fast path enters with done low; raise it for at least
          // one cycle before honouring a dropped enable.
          if (!enable && done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_ext_to_int64.sv
// tb/tb_fpu_ext_to_int64.sv - directed self-checking bench for fpu_ext_to_int64
module tb_fpu_ext_to_int64;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [79:0] real_in;
  logic [1:0]  round_mode;
  logic [63:0] int_out;
  logic        sign_out;
  logic        done;
  logic        error;
  logic        inexact;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] RN = 2'b00, DN = 2'b01, UP = 2'b10, CH = 2'b11;

  fpu_ext_to_int64 dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .real_in    (real_in),
    .round_mode (round_mode),
    .int_out    (int_out),
    .sign_out   (sign_out),
    .done       (done),
    .error      (error),
    .inexact    (inexact)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request/response: raise enable, count edges from capture to done,
  // check the results, drop enable and confirm done falls.
  task automatic run(input string tag, input logic [79:0] r, input logic [1:0] m,
                     input logic [63:0] e_int, input logic e_sign, input logic e_err,
                     input logic e_inex, input int e_lat);
    int lat;
    real_in    = r;
    round_mode = m;
    enable     = 1'b1;
    tick();                       // capture edge E0
    real_in    = ~r;              // later input changes must be ignored
    round_mode = ~m;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (done) break;
    end
    chk({tag, " latency"}, 64'(lat), 64'(e_lat));
    chk({tag, " int_out"}, int_out, e_int);
    chk({tag, " sign_out"}, {63'd0, sign_out}, {63'd0, e_sign});
    chk({tag, " error"}, {63'd0, error}, {63'd0, e_err});
    chk({tag, " inexact"}, {63'd0, inexact}, {63'd0, e_inex});
    enable = 1'b0;
    tick();
    chk({tag, " done_drop"}, {63'd0, done}, 64'd0);
    chk({tag, " hold_int"}, int_out, e_int);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    real_in    = 80'd0;
    round_mode = RN;
    tick();
    tick();
    reset = 1'b0;
    chk("rst int_out", int_out, 64'd0);
    chk("rst sign_out", {63'd0, sign_out}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst error", {63'd0, error}, 64'd0);
    chk("rst inexact", {63'd0, inexact}, 64'd0);

    run("p123",     80'h4005_F600_0000_0000_0000, RN, 64'd123, 1'b0, 1'b0, 1'b0, 59);
    run("n456",     80'hC007_E400_0000_0000_0000, RN, 64'd456, 1'b1, 1'b0, 1'b0, 57);
    run("2.5 rn",   80'h4000_A000_0000_0000_0000, RN, 64'd2,   1'b0, 1'b0, 1'b1, 64);
    run("2.5 up",   80'h4000_A000_0000_0000_0000, UP, 64'd3,   1'b0, 1'b0, 1'b1, 64);
    run("2.5 dn",   80'h4000_A000_0000_0000_0000, DN, 64'd2,   1'b0, 1'b0, 1'b1, 64);
    run("2.5 ch",   80'h4000_A000_0000_0000_0000, CH, 64'd2,   1'b0, 1'b0, 1'b1, 64);
    run("-2.5 dn",  80'hC000_A000_0000_0000_0000, DN, 64'd3,   1'b1, 1'b0, 1'b1, 64);
    run("bcd max",  80'h403A_DE0B_6B3A_763F_FFF0, RN, 64'h0DE0_B6B3_A763_FFFF, 1'b0, 1'b0, 1'b0, 6);
    run("bcd over", 80'h403A_DE0B_6B3A_7640_0000, RN, 64'd0,   1'b0, 1'b1, 1'b0, 6);
    run("nan",      80'h7FFF_C000_0000_0000_0000, RN, 64'd0,   1'b0, 1'b1, 1'b0, 1);
    run("exp big",  80'h403F_8000_0000_0000_0000, RN, 64'd0,   1'b0, 1'b1, 1'b0, 1);
    run("zero",     80'h0000_0000_0000_0000_0000, RN, 64'd0,   1'b0, 1'b0, 1'b0, 68);
    run("0.75 up",  80'h3FFE_C000_0000_0000_0000, UP, 64'd1,   1'b0, 1'b0, 1'b1, 66);
    run("0.75 ch",  80'h3FFE_C000_0000_0000_0000, CH, 64'd0,   1'b0, 1'b0, 1'b1, 66);
    run("-0.5 rn",  80'hBFFE_8000_0000_0000_0000, RN, 64'd0,   1'b1, 1'b0, 1'b1, 66);
    run("unnorm",   80'h403E_0000_0000_0000_0001, RN, 64'd1,   1'b0, 1'b0, 1'b0, 2);

    // enable dropped three cycles after capture: done must pulse for one cycle
    begin
      int seen;
      real_in    = 80'h4005_F600_0000_0000_0000;
      round_mode = RN;
      enable     = 1'b1;
      tick();
      tick(); tick(); tick();
      enable = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (done) begin seen = 1; break; end
      end
      chk("drop done seen", 64'(seen), 64'd1);
      chk("drop int_out", int_out, 64'd123);
      tick();
      chk("drop done pulse", {63'd0, done}, 64'd0);
      tick();
      chk("drop stays idle", {63'd0, done}, 64'd0);
    end

    // reset in the middle of SHIFT
    real_in    = 80'hC007_E400_0000_0000_0000;
    round_mode = RN;
    enable     = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst int_out", int_out, 64'd0);
    chk("midrst sign_out", {63'd0, sign_out}, 64'd0);
    chk("midrst done", {63'd0, done}, 64'd0);
    chk("midrst error", {63'd0, error}, 64'd0);
    chk("midrst inexact", {63'd0, inexact}, 64'd0);
    for (int i = 0; i < 60; i++) tick();
    chk("midrst no residual done", {63'd0, done}, 64'd0);
    run("post rst", 80'h4005_F600_0000_0000_0000, RN, 64'd123, 1'b0, 1'b0, 1'b0, 59);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_ext_to_int64.md
# fpu_ext_to_int64

Sequential converter from 80-bit extended-precision real to a 64-bit unsigned integer magnitude plus sign, rounded per the 8087 rounding-control field. It is the stage directly upstream of FPU_Binary_to_BCD in the FBSTP path; its `int_out`/`sign_out` feed that block's `binary_in`/`sign_in`. It range-checks against the 18-digit packed-BCD limit, so the downstream stage never sees an unrepresentable magnitude.

## Interface
- No parameters. Constants:
  - `BIAS_SHIFT` = 16446 (bias 16383 + 63)
  - `BCD_MAX` = 64'h0DE0_B6B3_A763_FFFF (10^18−1)
  - `MAX_SHIFT` = 66
- Ports:
  - `clk` input 1: sole clock, rising edge.
  - `reset` input 1: synchronous, active-high.
  - `enable` input 1: level request, held high until `done`.
  - `real_in` input 80: sign[79], exponent[78:64], explicit-integer-bit mantissa[63:0].
  - `round_mode` input 2: 00 nearest-even, 01 toward −inf, 10 toward +inf, 11 chop.
  - `int_out` output 64: rounded magnitude.
  - `sign_out` output 1: copy of `real_in[79]`.
  - `done` output 1: result valid.
  - `error` output 1: invalid operand or out of BCD range.
  - `inexact` output 1: guard|sticky nonzero.

## Operation
- States: IDLE, SHIFT, ROUND, DONE.
- IDLE: on `enable`=1, latch sign, mantissa, `round_mode`; guard=0, sticky=0.
  - Effective exponent: 1 if the exponent field is 0, otherwise the field value.
  - Exponent 7FFF (inf/NaN) or effective exponent > 16446: go to DONE with `error`=1, `int_out`=0, `inexact`=0.
  - Otherwise: cnt = min(16446 − eff_exp, 66); go to SHIFT.
- SHIFT: if cnt=0, go to ROUND. Else each cycle:
  - sticky |= guard
  - guard = mant[0]
  - mant >>= 1
  - cnt −= 1
- ROUND: compute inc (l = mant[0], g = guard, s = sticky):
  - RN: g&(l|s)
  - down: sign&(g|s)
  - up: ~sign&(g|s)
  - chop: 0
- ROUND, then: result = mant + inc.
  - If result > `BCD_MAX`: `error`=1, `int_out`=0.
  - Else: `int_out`=result, `error`=0.
  - `inexact` = g|s; `sign_out` = sign. A negative value that rounds to 0 keeps `sign_out`=1 (−0).
  - Go to DONE.
- DONE: `done`=1, outputs held. When `enable`=0, go to IDLE and drop `done` on that edge.
- Unnormals (bit 63 = 0, exponent nonzero) are converted numerically, with no special case.
- Inputs are sampled only at capture. Changes to `real_in`/`round_mode` afterward are ignored.

## Timing
- Reset: state IDLE; `int_out`=0, `sign_out`=0, `done`=0, `error`=0, `inexact`=0. Reset mid-conversion aborts immediately; there is no residual `done`.
- Capture edge E0, normal path:
  - E1..Ecnt: shifts.
  - Ecnt+1: SHIFT→ROUND.
  - Ecnt+2: results registered and `done`=1.
  - Latency is cnt+2 cycles, max 68.
- Error fast path: `done`=1 after E0+1.
- Outputs change only at the ROUND→DONE (or IDLE→DONE) edge. They hold through DONE and the following IDLE until the next capture.
- If `enable` drops mid-conversion, the conversion still completes. `done` is then high for exactly one cycle, and the state returns to IDLE on the next edge.
- `enable` high in DONE: `done` stays high indefinitely. A new conversion needs `enable` low for at least one edge.

## Test plan
- Exact integer: `real_in`=80'h4005_F600_0000_0000_0000 (123.0), RN -> `int_out`=123, `sign_out`=0, `error`=0, `inexact`=0, `done` 59 cycles after capture.
- Negative: 80'hC007_E400_0000_0000_0000 (−456.0) -> `int_out`=456, `sign_out`=1. Chain into FPU_Binary_to_BCD -> 80'h8000…0456.
- Rounding on 80'h4000_A000_0000_0000_0000 (2.5):
  - RN -> 2, up -> 3, down -> 2, chop -> 2; `inexact`=1 in all four modes.
  - Same with bit 79 set (−2.5), mode down -> 3, `sign_out`=1.
- BCD range at exponent 403A:
  - Mantissa DE0B6B3A763FFFF0 -> `int_out`=64'h0DE0_B6B3_A763_FFFF, `error`=0, latency 6.
  - Mantissa DE0B6B3A76400000 (10^18) -> `error`=1, `int_out`=0.
- Specials:
  - 80'h7FFF_C000_0000_0000_0000 (NaN) -> `error`=1, `done` 1 cycle after capture.
  - +0 -> `int_out`=0, `error`=0, latency 68.
  - 80'h3FFE_C000_0000_0000_0000 (0.75), mode up -> 1.
- Handshake and reset:
  - Drop `enable` 3 cycles after capture -> `done` pulses 1 cycle, then IDLE.
  - Assert `reset` mid-SHIFT -> all outputs 0 next edge; a following 123.0 request converts normally.
